// File: rtl/psum_drain_pkg.sv
// Shared PE configuration for the psum drain stage: vector geometry, config tags,
// drain settings and the FSM encoding.
package psum_drain_pkg;

    localparam int PE_ROW       = 8;
    localparam int PE_PSUMDWD   = 16;
    localparam int DRAIN_LANES  = 2;
    localparam int DRAIN_ODWD   = 8;
    localparam int DRAIN_ADDRWD = 10;

    typedef struct packed {
        logic [3:0] layer;
        logic [3:0] tile;
    } PSconf;

    typedef struct packed {
        logic [3:0]              shift;
        logic                    relu;
        logic [DRAIN_ADDRWD-1:0] base_addr;
    } DrainConf;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/psum_drain_if.sv
// Input vector channel (POUT) and output beat channel (OUT) of the psum drain stage.
interface psum_drain_if
    import psum_drain_pkg::*;
#(
    parameter int PEROW   = PE_ROW,
    parameter int PSUMDWD = PE_PSUMDWD,
    parameter int LANES   = DRAIN_LANES,
    parameter int ODWD    = DRAIN_ODWD,
    parameter int ADDRWD  = DRAIN_ADDRWD
);

    // Both channels: rdy is the sender's valid, ack the receiver's accept; a transfer
    // happens in any cycle where rdy && ack. Payload is only meaningful while rdy is high.
    logic                     POUT_rdy;
    logic                     POUT_ack;
    logic [PEROW*PSUMDWD-1:0] i_Psum_POUT;
    PSconf                    i_psconf_POUT;

    logic                     OUT_rdy;
    logic                     OUT_ack;
    logic [LANES*ODWD-1:0]    o_data;
    logic [ADDRWD-1:0]        o_addr;
    logic                     o_last;
    PSconf                    o_psconf;

    modport master (
        output POUT_rdy, i_Psum_POUT, i_psconf_POUT, OUT_ack,
        input  POUT_ack, OUT_rdy, o_data, o_addr, o_last, o_psconf
    );

    modport slave (
        input  POUT_rdy, i_Psum_POUT, i_psconf_POUT, OUT_ack,
        output POUT_ack, OUT_rdy, o_data, o_addr, o_last, o_psconf
    );

endinterface

// File: rtl/psum_quant.sv
// One-lane re-quantizer: optional ReLU, round-half-up arithmetic right shift, saturation.
module psum_quant #(
    parameter int IW = 16,
    parameter int OW = 8
) (
    input  logic signed [IW-1:0] x,
    input  logic        [3:0]    shift,
    input  logic                 relu,
    output logic signed [OW-1:0] y
);

    localparam logic signed [IW:0] Y_MAX = (IW+1)'((1 << (OW-1)) - 1);
    localparam logic signed [IW:0] Y_MIN = (IW+1)'(-(1 << (OW-1)));

    logic signed [IW-1:0] xr;
    logic signed [IW:0]   rnd;
    logic signed [IW:0]   r;
    logic signed [IW:0]   s;

    // One extra bit keeps x + rounding constant from wrapping at the positive end.
    always_comb begin
        xr  = (relu && x[IW-1]) ? '0 : x;
        rnd = '0;
        if (shift != 4'd0) begin
            rnd = (IW+1)'(1) << (shift - 4'd1);
        end
        r = (IW+1)'(xr) + rnd;
        s = r >>> shift;
        if (s > Y_MAX) begin
            y = Y_MAX[OW-1:0];
        end else if (s < Y_MIN) begin
            y = Y_MIN[OW-1:0];
        end else begin
            y = s[OW-1:0];
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Holds one psum vector and serializes it into LANES-wide quantized beats with an
// auto-incrementing output-buffer address.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int PEROW   = PE_ROW,
    parameter int PSUMDWD = PE_PSUMDWD,
    parameter int LANES   = DRAIN_LANES,
    parameter int ODWD    = DRAIN_ODWD,
    parameter int ADDRWD  = DRAIN_ADDRWD
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    psum_drain_if.slave       bus,
    input  logic [3:0]        i_shift,
    input  logic              i_relu,
    input  logic [ADDRWD-1:0] i_base_addr,
    input  logic              i_clear,
    output drain_state_t      dbg_state
);

    localparam int BEATS = PEROW / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (PEROW > 1) ? $clog2(PEROW) : 1;

    drain_state_t          state_q;
    drain_state_t          state_d;
    logic [BW-1:0]         beat_idx;
    logic [ADDRWD-1:0]     addr_q;
    logic [PSUMDWD-1:0]    vec_q [PEROW];
    logic [PSUMDWD-1:0]    vec_in [PEROW];
    PSconf                 psconf_q;
    DrainConf              cfg;
    logic                  last;
    logic                  in_xfer;
    logic                  beat_xfer;
    logic [LANES*ODWD-1:0] q_data;

    assign cfg = '{shift: i_shift, relu: i_relu, base_addr: DRAIN_ADDRWD'(i_base_addr)};

    for (genvar g = 0; g < PEROW; g++) begin : g_unpack
        assign vec_in[g] = bus.i_Psum_POUT[g*PSUMDWD +: PSUMDWD];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A new vector accepted on the last beat keeps the stage in DRAIN with no bubble.
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) state_d = ST_DRAIN;
                ST_DRAIN: if (beat_xfer && last && !in_xfer) state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        last         = (state_q == ST_DRAIN) && (beat_idx == BW'(BEATS - 1));
        bus.OUT_rdy  = (state_q == ST_DRAIN) && !i_clear;
        bus.POUT_ack = !i_clear && ((state_q == ST_EMPTY) ||
                                    ((state_q == ST_DRAIN) && last && bus.OUT_ack));
        bus.o_last   = last;
        in_xfer      = bus.POUT_rdy && bus.POUT_ack;
        beat_xfer    = bus.OUT_rdy && bus.OUT_ack;
        dbg_state    = state_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            beat_idx <= '0;
            addr_q   <= '0;
            psconf_q <= '0;
            for (int i = 0; i < PEROW; i++) begin
                vec_q[i] <= '0;
            end
        end else if (i_clear) begin
            beat_idx <= '0;
            addr_q   <= ADDRWD'(cfg.base_addr);
        end else begin
            if (beat_xfer) begin
                addr_q <= addr_q + ADDRWD'(1);
            end
            if (in_xfer) begin
                vec_q    <= vec_in;
                psconf_q <= bus.i_psconf_POUT;
                beat_idx <= '0;
            end else if (beat_xfer) begin
                beat_idx <= beat_idx + BW'(1);
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LW-1:0]          lane_idx;
        logic signed [ODWD-1:0] q;

        assign lane_idx = LW'(int'(beat_idx) * LANES + k);

        psum_quant #(
            .IW (PSUMDWD),
            .OW (ODWD)
        ) u_quant (
            .x     (vec_q[lane_idx]),
            .shift (cfg.shift),
            .relu  (cfg.relu),
            .y     (q)
        );

        assign q_data[k*ODWD +: ODWD] = q;
    end

    assign bus.o_data   = q_data;
    assign bus.o_addr   = addr_q;
    assign bus.o_psconf = psconf_q;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: beat order, quantization corners, back-to-back vectors,
// stalls, address wrap and clear.
module tb_psum_drain;
    import psum_drain_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_rstn;
    logic [3:0]   i_shift;
    logic         i_relu;
    logic [9:0]   i_base_addr;
    logic         i_clear;
    drain_state_t dbg_state;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [34:0]  exp_q[$];
    logic [34:0]  mon_e;
    logic [9:0]   exp_addr = '0;

    psum_drain_if #(.PEROW(8), .PSUMDWD(16), .LANES(2), .ODWD(8), .ADDRWD(10)) bus ();

    psum_drain #(.PEROW(8), .PSUMDWD(16), .LANES(2), .ODWD(8), .ADDRWD(10)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .bus         (bus),
        .i_shift     (i_shift),
        .i_relu      (i_relu),
        .i_base_addr (i_base_addr),
        .i_clear     (i_clear),
        .dbg_state   (dbg_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] pk16(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [63:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Scoreboard entry: {tag, last, addr, data}
    task automatic expect_vec(input logic [63:0] e, input logic [7:0] tag, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            exp_q.push_back({tag, (b == 3), exp_addr, e[b*16 +: 16]});
            exp_addr = exp_addr + 10'd1;
        end
    endtask

    task automatic offer(input logic [127:0] v, input logic [7:0] tag);
        bus.i_Psum_POUT   = v;
        bus.i_psconf_POUT = tag;
        bus.POUT_rdy      = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (bus.POUT_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_seen", 32'(ok), 1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !bus.OUT_rdy) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_clk);
            #1;
        end
        check("drain_done", 32'(ok), 1);
    endtask

    task automatic do_clear(input logic [9:0] base);
        i_base_addr = base;
        i_clear     = 1'b1;
        @(negedge i_clk);
        check("clr_out_rdy", 32'(bus.OUT_rdy), 0);
        check("clr_pout_ack", 32'(bus.POUT_ack), 0);
        @(posedge i_clk);
        #1;
        i_clear  = 1'b0;
        exp_addr = base;
    endtask

    task automatic run_vec(input logic [127:0] v, input logic [63:0] e, input logic [7:0] tag,
                           input logic [3:0] sh, input logic rl);
        i_shift = sh;
        i_relu  = rl;
        expect_vec(e, tag, 4);
        offer(v, tag);
        wait_accept();
        bus.POUT_rdy = 1'b0;
        drain();
    endtask

    always @(negedge i_clk) begin
        if (i_rstn && bus.OUT_rdy && bus.OUT_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(bus.o_addr), 32'h3ff);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", 32'(bus.o_data), 32'(mon_e[15:0]));
                check("beat_addr", 32'(bus.o_addr), 32'(mon_e[25:16]));
                check("beat_last", 32'(bus.o_last), 32'(mon_e[26]));
                check("beat_tag", 32'(bus.o_psconf), 32'(mon_e[34:27]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i_rstn            = 1'b0;
        i_shift           = 4'd0;
        i_relu            = 1'b0;
        i_base_addr       = '0;
        i_clear           = 1'b0;
        bus.POUT_rdy      = 1'b0;
        bus.i_Psum_POUT   = '0;
        bus.i_psconf_POUT = '0;
        bus.OUT_ack       = 1'b0;

        @(negedge i_clk);
        check("rst_out_rdy", 32'(bus.OUT_rdy), 0);
        check("rst_o_last", 32'(bus.o_last), 0);
        check("rst_o_data", 32'(bus.o_data), 0);
        check("rst_o_addr", 32'(bus.o_addr), 0);
        check("rst_o_psconf", 32'(bus.o_psconf), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_EMPTY));
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        @(negedge i_clk);
        check("post_rst_pout_ack", 32'(bus.POUT_ack), 1);
        check("post_rst_out_rdy", 32'(bus.OUT_rdy), 0);
        @(posedge i_clk);
        #1;

        // Basic vector, latency and POUT_ack pattern
        bus.OUT_ack = 1'b1;
        do_clear(10'd0);
        expect_vec(pk8(1, 2, 3, 4, 5, 6, 7, 8), 8'hA1, 4);
        offer(pk16(1, 2, 3, 4, 5, 6, 7, 8), 8'hA1);
        wait_accept();
        bus.POUT_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check("t1_out_rdy", 32'(bus.OUT_rdy), 1);
            check("t1_pout_ack", 32'(bus.POUT_ack), (i == 3) ? 1 : 0);
        end
        @(posedge i_clk);
        #1;
        drain();
        check("t1_idle_state", 32'(dbg_state), 32'(ST_EMPTY));

        // Quantization corners
        run_vec(pk16(300, 6, -6, 2, -2, 0, 509, 3),
                pk8(75, 2, -1, 1, 0, 0, 127, 1), 8'h12, 4'd2, 1'b0);
        run_vec(pk16(-7, 7, -1, 1, 255, 256, -256, -257),
                pk8(-3, 4, 0, 1, 127, 127, -128, -128), 8'h13, 4'd1, 1'b0);
        run_vec(pk16(1000, -1000, 127, -128, 128, -129, 32767, -32768),
                pk8(127, -128, 127, -128, 127, -128, 127, -128), 8'h14, 4'd0, 1'b0);
        run_vec(pk16(-5, 1000, -1, 5, -32768, 32767, 0, -128),
                pk8(0, 127, 0, 5, 0, 127, 0, 0), 8'h15, 4'd0, 1'b1);
        run_vec(pk16(32767, -32768, 16384, 16383, -16384, -16385, 0, 1),
                pk8(1, -1, 1, 0, 0, -1, 0, 0), 8'h16, 4'd15, 1'b0);

        // Back-to-back vectors with no bubble
        i_shift = 4'd0;
        i_relu  = 1'b0;
        do_clear(10'd0);
        expect_vec(pk8(1, 2, 3, 4, 5, 6, 7, 8), 8'h21, 4);
        expect_vec(pk8(-1, -2, -3, -4, -5, -6, -7, -8), 8'h22, 4);
        offer(pk16(1, 2, 3, 4, 5, 6, 7, 8), 8'h21);
        wait_accept();
        offer(pk16(-1, -2, -3, -4, -5, -6, -7, -8), 8'h22);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            check("b2b_out_rdy", 32'(bus.OUT_rdy), 1);
            check("b2b_pout_ack", 32'(bus.POUT_ack), (i == 3 || i == 7) ? 1 : 0);
            if (i == 3) begin
                @(posedge i_clk);
                #1;
                bus.POUT_rdy = 1'b0;
            end
        end
        @(posedge i_clk);
        #1;
        drain();

        // Stall on beat 1 with a new vector waiting upstream
        do_clear(10'd0);
        expect_vec(pk8(10, 20, 30, 40, 50, 60, 70, 80), 8'h31, 4);
        expect_vec(pk8(-10, -20, -30, -40, -50, -60, -70, -80), 8'h32, 4);
        offer(pk16(10, 20, 30, 40, 50, 60, 70, 80), 8'h31);
        wait_accept();
        offer(pk16(-10, -20, -30, -40, -50, -60, -70, -80), 8'h32);
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        bus.OUT_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("stall_out_rdy", 32'(bus.OUT_rdy), 1);
            check("stall_data", 32'(bus.o_data), 32'h281e);
            check("stall_addr", 32'(bus.o_addr), 1);
            check("stall_last", 32'(bus.o_last), 0);
            check("stall_pout_ack", 32'(bus.POUT_ack), 0);
            @(posedge i_clk);
            #1;
        end
        bus.OUT_ack = 1'b1;
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("stall_resume_pout_ack", 32'(bus.POUT_ack), 1);
        @(posedge i_clk);
        #1;
        bus.POUT_rdy = 1'b0;
        drain();

        // Address wrap: 1022, 1023, 0, 1
        do_clear(10'd1022);
        run_vec(pk16(-1, 1, -2, 2, -3, 3, -4, 4),
                pk8(-1, 1, -2, 2, -3, 3, -4, 4), 8'h41, 4'd0, 1'b0);
        check("wrap_addr_after", 32'(bus.o_addr), 2);

        // Clear during beat 2 drops the rest of the vector
        expect_vec(pk8(11, 12, 13, 14, 15, 16, 17, 18), 8'h51, 2);
        offer(pk16(11, 12, 13, 14, 15, 16, 17, 18), 8'h51);
        wait_accept();
        bus.POUT_rdy = 1'b0;
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_base_addr = 10'd100;
        i_clear     = 1'b1;
        @(negedge i_clk);
        check("clr_mid_out_rdy", 32'(bus.OUT_rdy), 0);
        check("clr_mid_pout_ack", 32'(bus.POUT_ack), 0);
        @(posedge i_clk);
        #1;
        i_clear  = 1'b0;
        exp_addr = 10'd100;
        @(negedge i_clk);
        check("after_clr_out_rdy", 32'(bus.OUT_rdy), 0);
        check("after_clr_pout_ack", 32'(bus.POUT_ack), 1);
        check("after_clr_state", 32'(dbg_state), 32'(ST_EMPTY));
        check("after_clr_addr", 32'(bus.o_addr), 100);
        @(posedge i_clk);
        #1;
        run_vec(pk16(21, 22, 23, 24, 25, 26, 27, 28),
                pk8(21, 22, 23, 24, 25, 26, 27, 28), 8'h52, 4'd0, 1'b0);

        repeat (3) @(posedge i_clk);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
